reaction_timer_core: RTL and testbench
======================================

Name: reaction_timer_core

Overview:
Consumer end of the random-pattern generator. On START it captures an 11-bit random delay and a 10-bit LED pattern, waits MIN_DELAY plus the random delay (in ms ticks), then lights the pattern. It measures the time in milliseconds until the player presses BTN. It sits between the random generator and the score/display logic, and flags false starts and timeouts.

Parameters:
TICK_DIV, 50000, CLK cycles per 1 ms tick (50 MHz clock); must be ≥2.
MIN_DELAY, 1000, fixed ms added to the random delay.
MAX_MS, 9999, reaction count ceiling; reaching it ends the round as a timeout.

Ports:
CLK  input  1  system clock; all flops on rising edge.
RST  input  1  asynchronous, active-high reset.
START  input  1  synchronous request to begin a round; level-sampled.
BTN  input  1  raw asynchronous player button, active-high.
RAND_Q  input  11  random delay from the generator, in ms.
RAND_LED  input  10  random LED pattern from the generator.
LED  output  10  stimulus LEDs.
RESULT_MS  output  14  measured reaction time in ms.
VALID  output  1  high while in DONE (result is valid).
FOUL  output  1  high while in FOUL (button pressed during wait).
TIMEOUT  output  1  high in DONE when the round ended at MAX_MS.
BUSY  output  1  high in WAIT or REACT.

Behaviour:
- Reset (async, any state): state=IDLE; LED=0; RESULT_MS=0; VALID, FOUL, TIMEOUT, BUSY=0; prescaler=0; sync flops=0.
- BTN path:
  - Two-flop synchronizer, then a rising-edge detector giving a 1-cycle PRESS pulse.
  - BTN high before the rising edge of cycle n gives PRESS high during cycle n+2.
  - A held button yields exactly one PRESS.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - TICK is a 1-cycle pulse when the count equals TICK_DIV-1.
  - Prescaler clears to 0 on every state transition.
- States: IDLE, WAIT, REACT, DONE, FOUL.
- IDLE/DONE/FOUL, START=1:
  - delay_cnt ← MIN_DELAY + RAND_Q (14 bit).
  - pattern ← RAND_LED, or 10'b0000000001 if RAND_LED==0.
  - Clear RESULT_MS, VALID, FOUL, TIMEOUT; go to WAIT next cycle.
  - START in any other state is ignored.
- WAIT:
  - BUSY=1, LED=0.
  - Each TICK decrements delay_cnt.
  - TICK with delay_cnt==1: go to REACT, LED←pattern, ms_cnt←0.
  - PRESS in WAIT: go to FOUL (FOUL=1, LED=10'h3FF, BUSY=0). PRESS has priority over a same-cycle final TICK.
- REACT:
  - BUSY=1, LED=pattern.
  - Each TICK increments ms_cnt.
  - PRESS: go to DONE; RESULT_MS←ms_cnt (value before any same-cycle increment); VALID=1; LED=0.
  - TICK with ms_cnt==MAX_MS-1 and no PRESS: go to DONE; RESULT_MS←MAX_MS; VALID=1; TIMEOUT=1; LED=0.
- DONE/FOUL: outputs hold until START or RST.
- RST asserted mid-round: immediate return to IDLE with all outputs at reset values; no partial result is reported.
- Width: RESULT_MS saturates at MAX_MS and never wraps. MIN_DELAY+2047 must fit in 14 bits.

Test Plan (TICK_DIV=4, MIN_DELAY=2, MAX_MS=20):
1. Normal round: RAND_Q=3, RAND_LED=10'h155, START 1 cycle.
   - BUSY rises next cycle.
   - LED=10'h155 after 5 ticks (20 cycles) in WAIT.
   - BTN raised 7 ticks into REACT gives VALID=1, RESULT_MS=7, LED=0, TIMEOUT=0.
2. False start: RAND_Q=3, BTN pressed 2 ticks into WAIT → FOUL=1, LED=10'h3FF, BUSY=0, VALID=0; LED never shows the pattern.
3. Timeout: RAND_Q=0, no BTN → after 20 ticks in REACT: VALID=1, TIMEOUT=1, RESULT_MS=20.
4. Zero pattern and held button:
   - RAND_LED=0 → LED=10'h001 in REACT.
   - BTN held high from before START → no PRESS edge, so no FOUL.
5. Edge cases:
   - START pulsed during WAIT and during REACT → no restart, counts unaffected.
   - PRESS coincident with a TICK in REACT at ms_cnt=4 → RESULT_MS=4.
6. Async reset: RST asserted mid-REACT between clock edges → LED, BUSY, VALID go to 0 immediately. After release, START begins a clean round with RESULT_MS=0.

Source files
------------

// File: rtl/reaction_timer_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | reaction_timer_core : randomised-delay reaction timer with false-start   |
// |                       and timeout detection, millisecond resolution.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module reaction_timer_core #(
   parameter int TICK_DIV  = 50000,
   parameter int MIN_DELAY = 1000,
   parameter int MAX_MS    = 9999
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        START,
   input  logic        BTN,
   input  logic [10:0] RAND_Q,
   input  logic [9:0]  RAND_LED,
   output logic [9:0]  LED,
   output logic [13:0] RESULT_MS,
   output logic        VALID,
   output logic        FOUL,
   output logic        TIMEOUT,
   output logic        BUSY
);

   localparam int              c_PW        = $clog2(TICK_DIV);
   localparam logic [c_PW-1:0] c_TICK_LAST = c_PW'(TICK_DIV - 1);
   localparam logic [13:0]     c_MIN_DELAY = 14'(MIN_DELAY);
   localparam logic [13:0]     c_MAX_MS    = 14'(MAX_MS);
   localparam logic [13:0]     c_MAX_M1    = 14'(MAX_MS - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAIT  = 3'd1,
      S_REACT = 3'd2,
      S_DONE  = 3'd3,
      S_FOUL  = 3'd4
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [c_PW-1:0]  r_presc;
   logic [13:0]      r_delay_cnt, r_ms_cnt, r_result;
   logic [9:0]       r_pattern;
   logic             r_timeout;
   logic             r_btn_meta, r_btn_sync, r_btn_prev;
   logic             w_press, w_tick;
   logic             w_load, w_dec, w_enter_react, w_inc, w_capture, w_expire;

   assign w_press = r_btn_sync & ~r_btn_prev;
   assign w_tick  = (r_presc == c_TICK_LAST);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_btn_meta <= 1'b0;
         r_btn_sync <= 1'b0;
         r_btn_prev <= 1'b0;
      end else begin
         r_btn_meta <= BTN;
         r_btn_sync <= r_btn_meta;
         r_btn_prev <= r_btn_sync;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // PRESS is tested before TICK so a press always wins a coincident tick.
   always_comb begin
      w_state_nxt   = r_state;
      w_load        = 1'b0;
      w_dec         = 1'b0;
      w_enter_react = 1'b0;
      w_inc         = 1'b0;
      w_capture     = 1'b0;
      w_expire      = 1'b0;
      case (r_state)
         S_WAIT: begin
            if (w_press) begin
               w_state_nxt = S_FOUL;
            end else if (w_tick) begin
               if (r_delay_cnt == 14'd1) begin
                  w_state_nxt   = S_REACT;
                  w_enter_react = 1'b1;
               end else begin
                  w_dec = 1'b1;
               end
            end
         end
         S_REACT: begin
            if (w_press) begin
               w_state_nxt = S_DONE;
               w_capture   = 1'b1;
            end else if (w_tick) begin
               if (r_ms_cnt == c_MAX_M1) begin
                  w_state_nxt = S_DONE;
                  w_expire    = 1'b1;
               end else begin
                  w_inc = 1'b1;
               end
            end
         end
         default: begin
            if (START) begin
               w_state_nxt = S_WAIT;
               w_load      = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_presc     <= '0;
         r_delay_cnt <= '0;
         r_ms_cnt    <= '0;
         r_result    <= '0;
         r_pattern   <= '0;
         r_timeout   <= 1'b0;
      end else begin
         if (w_state_nxt != r_state || w_tick) r_presc <= '0;
         else                                  r_presc <= r_presc + 1'b1;

         if (w_load) begin
            r_delay_cnt <= c_MIN_DELAY + {3'b000, RAND_Q};
            r_pattern   <= (RAND_LED == 10'd0) ? 10'd1 : RAND_LED;
            r_result    <= '0;
            r_timeout   <= 1'b0;
         end else if (w_dec) begin
            r_delay_cnt <= r_delay_cnt - 14'd1;
         end

         if (w_enter_react)  r_ms_cnt <= '0;
         else if (w_inc)     r_ms_cnt <= r_ms_cnt + 14'd1;

         if (w_capture) begin
            r_result <= r_ms_cnt;
         end else if (w_expire) begin
            r_result  <= c_MAX_MS;
            r_timeout <= 1'b1;
         end
      end
   end

   // Outputs decode from state so an async reset clears them immediately.
   always_comb begin
      LED = 10'd0;
      if (r_state == S_REACT)     LED = r_pattern;
      else if (r_state == S_FOUL) LED = 10'h3FF;
   end

   assign RESULT_MS = r_result;
   assign VALID     = (r_state == S_DONE);
   assign FOUL      = (r_state == S_FOUL);
   assign TIMEOUT   = (r_state == S_DONE) & r_timeout;
   assign BUSY      = (r_state == S_WAIT) | (r_state == S_REACT);

endmodule
`default_nettype wire

// File: tb/tb_reaction_timer_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_reaction_timer_core : directed self-checking bench for the timer.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_reaction_timer_core;

   logic        CLK = 1'b0;
   logic        RST, START, BTN;
   logic [10:0] RAND_Q;
   logic [9:0]  RAND_LED, LED;
   logic [13:0] RESULT_MS;
   logic        VALID, FOUL, TIMEOUT, BUSY;
   int          n_tests = 0;
   int          n_fail  = 0;

   reaction_timer_core #(.TICK_DIV(4), .MIN_DELAY(2), .MAX_MS(20)) dut (
      .CLK(CLK), .RST(RST), .START(START), .BTN(BTN),
      .RAND_Q(RAND_Q), .RAND_LED(RAND_LED), .LED(LED),
      .RESULT_MS(RESULT_MS), .VALID(VALID), .FOUL(FOUL),
      .TIMEOUT(TIMEOUT), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic begin_round(input logic [10:0] q, input logic [9:0] pat);
      RAND_Q = q; RAND_LED = pat; START = 1'b1;
      step(1);
      START = 1'b0;
   endtask

   initial begin
      RST = 1'b1; START = 1'b0; BTN = 1'b0; RAND_Q = '0; RAND_LED = '0;
      step(3);
      chk("rst_led", LED, 0);
      chk("rst_result", RESULT_MS, 0);
      chk("rst_flags", {VALID, FOUL, TIMEOUT, BUSY}, 4'b0000);
      RST = 1'b0;
      step(2);

      // 1: normal round, delay 5 ticks, press 7 ticks into REACT
      begin_round(11'd3, 10'h155);
      chk("t1_busy", BUSY, 1);
      chk("t1_wait_led", LED, 0);
      step(19);
      chk("t1_still_wait", LED, 0);
      step(1);
      chk("t1_pattern", LED, 10'h155);
      step(28);
      BTN = 1'b1;
      step(2);
      chk("t1_not_yet", VALID, 0);
      step(1);
      chk("t1_valid", VALID, 1);
      chk("t1_result", RESULT_MS, 7);
      chk("t1_led_off", LED, 0);
      chk("t1_timeout", TIMEOUT, 0);
      chk("t1_busy_off", BUSY, 0);
      BTN = 1'b0;
      step(3);

      // 2: false start
      begin_round(11'd3, 10'h0AA);
      step(8);
      BTN = 1'b1;
      step(2);
      chk("t2_led_dark", LED, 0);
      step(1);
      chk("t2_foul", FOUL, 1);
      chk("t2_led", LED, 10'h3FF);
      chk("t2_flags", {VALID, BUSY}, 2'b00);
      BTN = 1'b0;
      step(3);
      chk("t2_hold", {FOUL, LED}, {1'b1, 10'h3FF});

      // 3: timeout
      begin_round(11'd0, 10'h0F0);
      chk("t3_clear", {FOUL, VALID}, 2'b00);
      step(8);
      chk("t3_pattern", LED, 10'h0F0);
      step(79);
      chk("t3_pending", {BUSY, VALID}, 2'b10);
      step(1);
      chk("t3_valid", VALID, 1);
      chk("t3_timeout", TIMEOUT, 1);
      chk("t3_result", RESULT_MS, 20);
      chk("t3_led", LED, 0);

      // 4: zero pattern, button held since before START
      BTN = 1'b1;
      step(3);
      begin_round(11'd0, 10'h000);
      chk("t4_clear_to", TIMEOUT, 0);
      step(8);
      chk("t4_led", LED, 10'h001);
      chk("t4_no_foul", {FOUL, BUSY}, 2'b01);
      BTN = 1'b0;
      step(3);
      BTN = 1'b1;
      step(3);
      chk("t4_valid", VALID, 1);
      chk("t4_result", RESULT_MS, 1);
      BTN = 1'b0;
      step(3);

      // 5: START ignored while busy; press coincident with tick at ms=4
      begin_round(11'd1, 10'h3C3);
      step(5);
      START = 1'b1;
      step(1);
      START = 1'b0;
      step(5);
      chk("t5_wait_end", LED, 0);
      step(1);
      chk("t5_react", LED, 10'h3C3);
      step(5);
      START = 1'b1;
      step(1);
      START = 1'b0;
      chk("t5_still_react", {BUSY, LED}, {1'b1, 10'h3C3});
      step(11);
      BTN = 1'b1;
      step(2);
      chk("t5_busy", BUSY, 1);
      step(1);
      chk("t5_valid", VALID, 1);
      chk("t5_result", RESULT_MS, 4);
      BTN = 1'b0;
      step(3);

      // 6: async reset mid-REACT
      begin_round(11'd0, 10'h1FF);
      step(8);
      chk("t6_react", LED, 10'h1FF);
      step(5);
      #2;
      RST = 1'b1;
      #1;
      chk("t6_async", {LED, BUSY, VALID}, 12'd0);
      chk("t6_result", RESULT_MS, 0);
      step(1);
      RST = 1'b0;
      step(1);
      begin_round(11'd0, 10'h00F);
      chk("t6_new_busy", BUSY, 1);
      chk("t6_new_result", RESULT_MS, 0);
      step(8);
      chk("t6_new_led", LED, 10'h00F);
      BTN = 1'b1;
      step(3);
      chk("t6_new_done", {VALID, TIMEOUT}, 2'b10);
      chk("t6_new_val", RESULT_MS, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
